// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the 4-bit CPU control path: timing states, opcodes
// and the field layout of the 6-bit instruction word {F, Rx, Ry}.
package cpu_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam int F_HI  = 5;
  localparam int F_LO  = 4;
  localparam int RX_HI = 3;
  localparam int RX_LO = 2;
  localparam int RY_HI = 1;
  localparam int RY_LO = 0;

  // ADD and SUB share the three-step ALU sequence; both have F[1] set.
  function automatic logic is_alu(input logic [1:0] f);
    return f[1];
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Handshake and control-bundle between the instruction source and the
// control sequencer; the sequencer uses the slave view.
interface cpu_control_fsm_if;
  logic       w;
  logic [5:0] Func;
  logic [3:0] Rin;
  logic [3:0] Rout;
  logic       Extern;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  modport master (
    output w, Func,
    input  Rin, Rout, Extern, Gout, Ain, Gin, AddSub, Done
  );

  modport slave (
    input  w, Func,
    output Rin, Rout, Extern, Gout, Ain, Gin, AddSub, Done
  );
endinterface

// File: rtl/cpu_control_fsm_dec2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Control sequencer for the 4-bit CPU: latches an instruction on w in T0 and
// walks T1..T3 driving register enables, ALU controls and bus drive enables.
module cpu_control_fsm
  import cpu_pkg::*;
(
  input logic              Clock,
  input logic              Resetn,
  cpu_control_fsm_if.slave bus
);

  state_t     state, state_nxt;
  logic [5:0] ir;
  logic [1:0] f, rx, ry;

  logic rin_en, rout_rx, rout_ry;
  logic extern_en, gout_en, ain_en, gin_en, addsub, done;
  logic [3:0] rx_oh, ry_oh;

  assign f  = ir[F_HI:F_LO];
  assign rx = ir[RX_HI:RX_LO];
  assign ry = ir[RY_HI:RY_LO];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= T0;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                    ir <= 6'd0;
    else if (state == T0 && bus.w)  ir <= bus.Func;
  end

  always_comb begin
    state_nxt = state;
    rin_en    = 1'b0;
    rout_rx   = 1'b0;
    rout_ry   = 1'b0;
    extern_en = 1'b0;
    gout_en   = 1'b0;
    ain_en    = 1'b0;
    gin_en    = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    unique case (state)
      T0: if (bus.w) state_nxt = T1;
      T1: begin
        if (is_alu(f)) begin
          state_nxt = T2;
          rout_rx   = 1'b1;
          ain_en    = 1'b1;
        end else begin
          state_nxt = T0;
          rin_en    = 1'b1;
          done      = 1'b1;
          if (f == OP_LOAD) extern_en = 1'b1;
          else              rout_ry   = 1'b1;
        end
      end
      T2: begin
        state_nxt = T3;
        rout_ry   = 1'b1;
        gin_en    = 1'b1;
        addsub    = f[0];
      end
      T3: begin
        state_nxt = T0;
        gout_en   = 1'b1;
        rin_en    = 1'b1;
        done      = 1'b1;
      end
      default: state_nxt = T0;
    endcase
  end

  // Rx never feeds Rin and Rout in the same state, so one Rx decoder serves both.
  dec2to4 u_dec_rx (
    .en  (rin_en | rout_rx),
    .sel (rx),
    .y   (rx_oh)
  );

  dec2to4 u_dec_ry (
    .en  (rout_ry),
    .sel (ry),
    .y   (ry_oh)
  );

  assign bus.Rin    = rx_oh & {4{rin_en}};
  assign bus.Rout   = (rx_oh & {4{rout_rx}}) | ry_oh;
  assign bus.Extern = extern_en;
  assign bus.Gout   = gout_en;
  assign bus.Ain    = ain_en;
  assign bus.Gin    = gin_en;
  assign bus.AddSub = addsub;
  assign bus.Done   = done;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm plus a randomized bus-exclusivity run.
module tb_cpu_control_fsm;

  logic Clock;
  logic Resetn;
  int   errors;
  int   checks;

  cpu_control_fsm_if bus_if ();

  cpu_control_fsm dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_if)
  );

  // {Rin, Rout, Extern, Gout, Ain, Gin, AddSub, Done}
  logic [13:0] outs;
  assign outs = {bus_if.Rin, bus_if.Rout, bus_if.Extern, bus_if.Gout,
                 bus_if.Ain, bus_if.Gin, bus_if.AddSub, bus_if.Done};

  logic [5:0] drv;
  assign drv = {bus_if.Rout, bus_if.Extern, bus_if.Gout};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic test_reset();
    Resetn = 1'b0;
    bus_if.w = 1'b0;
    bus_if.Func = 6'd0;
    #1;
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL reset_async outs=%b expected=%b", outs, 14'd0);
    end
    checks++;
    if ($countones(drv) > 1) begin
      errors++;
      $display("FAIL reset_bus drivers=%b expected at most one", drv);
    end
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      checks++;
      if (outs !== 14'd0) begin
        errors++;
        $display("FAIL idle_%0d outs=%b expected=%b", i, outs, 14'd0);
      end
    end
  endtask

  task automatic test_load();
    bus_if.w = 1'b1;
    bus_if.Func = 6'b00_10_01;
    @(negedge Clock);
    bus_if.w = 1'b0;
    checks++;
    if (outs !== {4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL load_t1 outs=%b expected=%b", outs,
               {4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge Clock);
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL load_after outs=%b expected=%b", outs, 14'd0);
    end
  endtask

  task automatic test_move();
    bus_if.w = 1'b1;
    bus_if.Func = 6'b01_01_11;
    @(negedge Clock);
    bus_if.w = 1'b0;
    checks++;
    if (outs !== {4'b0010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL move_t1 outs=%b expected=%b", outs,
               {4'b0010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge Clock);
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL move_after outs=%b expected=%b", outs, 14'd0);
    end
  endtask

  task automatic test_sub();
    bus_if.w = 1'b1;
    bus_if.Func = 6'b11_00_10;
    @(negedge Clock);
    bus_if.w = 1'b0;
    checks++;
    if (outs !== {4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_t1 outs=%b expected=%b", outs,
               {4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    @(negedge Clock);
    bus_if.Func = 6'b00_11_11;
    #1;
    checks++;
    if (outs !== {4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_t2 outs=%b expected=%b", outs,
               {4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    @(negedge Clock);
    checks++;
    if (outs !== {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_t3 outs=%b expected=%b", outs,
               {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge Clock);
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL sub_after outs=%b expected=%b", outs, 14'd0);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.w = 1'b1;
    bus_if.Func = 6'b01_10_10;
    @(negedge Clock);
    bus_if.Func = 6'b00_11_00;
    checks++;
    if (outs !== {4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_move_same outs=%b expected=%b", outs,
               {4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge Clock);
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL b2b_gap outs=%b expected=%b", outs, 14'd0);
    end
    @(negedge Clock);
    bus_if.w = 1'b0;
    checks++;
    if (outs !== {4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_load outs=%b expected=%b", outs,
               {4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid_add();
    bus_if.w = 1'b1;
    bus_if.Func = 6'b10_11_00;
    @(negedge Clock);
    bus_if.w = 1'b0;
    checks++;
    if (outs !== {4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_t1 outs=%b expected=%b", outs,
               {4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    @(negedge Clock);
    checks++;
    if (outs !== {4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_t2 outs=%b expected=%b", outs,
               {4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    #2;
    Resetn = 1'b0;
    #1;
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL add_abort outs=%b expected=%b", outs, 14'd0);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_if.Done !== 1'b0) begin
        errors++;
        $display("FAIL add_no_done_%0d Done=%b expected=0", i, bus_if.Done);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_random();
    int         m_st;
    logic [5:0] m_ir;
    int         starts;
    int         dones;
    int         cyc;
    logic       wv;
    logic [5:0] fv;
    logic       exp_done;
    m_st   = 0;
    m_ir   = 6'd0;
    starts = 0;
    dones  = 0;
    cyc    = 0;
    while ((starts < 200 || m_st != 0) && cyc < 5000) begin
      wv = (starts < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      fv = 6'($urandom);
      bus_if.w = wv;
      bus_if.Func = fv;
      @(negedge Clock);
      cyc++;
      case (m_st)
        0: if (wv) begin m_ir = fv; m_st = 1; starts++; end
        1: m_st = m_ir[5] ? 2 : 0;
        2: m_st = 3;
        default: m_st = 0;
      endcase
      exp_done = (m_st == 1 && !m_ir[5]) || (m_st == 3);
      if (bus_if.Done === 1'b1) dones++;
      checks++;
      if ($countones(drv) > 1) begin
        errors++;
        $display("FAIL rnd_bus cyc=%0d drivers=%b expected at most one", cyc, drv);
      end
      checks++;
      if (bus_if.Done !== exp_done) begin
        errors++;
        $display("FAIL rnd_done cyc=%0d Done=%b expected=%b", cyc, bus_if.Done, exp_done);
      end
    end
    bus_if.w = 1'b0;
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL rnd_timeout starts=%0d expected=200", starts);
    end
    checks++;
    if (dones != starts) begin
      errors++;
      $display("FAIL rnd_done_count dones=%0d expected=%0d", dones, starts);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load();
    test_move();
    test_sub();
    test_back_to_back();
    test_reset_mid_add();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Control sequencer for the 4-bit CPU. It latches a 6-bit instruction word on a start strobe and steps through timing states T0–T3. In each state it drives the register load enables, ALU controls and the output-enables of every tristate buffer on the shared 4-bit bus. It sits directly upstream of the bus tristate buffers and register file, and guarantees that at most one buffer drives the bus in any cycle.

## Interface
- Parameters: none; the 4-register, 2-bit-field encoding is fixed.
- Clock  in  1  rising-edge system clock
- Resetn  in  1  asynchronous, active-low reset
- w  in  1  start strobe; sampled only in T0
- Func  in  6  instruction word {F[1:0], Rx[1:0], Ry[1:0]}; sampled with w
- Rin  out  4  one-hot register load enables (R0..R3)
- Rout  out  4  one-hot register bus-drive enables, feeding the tristate buffers
- Extern  out  1  external-data bus-drive enable
- Gout  out  1  ALU result register G bus-drive enable
- Ain  out  1  load enable for ALU operand register A
- Gin  out  1  load enable for G
- AddSub  out  1  ALU operation: 0 = add, 1 = subtract
- Done  out  1  high in the final cycle of each instruction

## Operation
- Opcodes F: 00 = LOAD (Rx ← Data), 01 = MOVE (Rx ← Ry), 10 = ADD (Rx ← Rx+Ry), 11 = SUB (Rx ← Rx−Ry).
- Instruction latch IR (6 bits):
  - Written only on an edge where state = T0 and w = 1.
  - Holds steady through T1–T3.
- State register holds T0..T3. Transitions:
  - T0 → T1 if w = 1, else stays in T0.
  - T1 → T0 for LOAD/MOVE; T1 → T2 for ADD/SUB.
  - T2 → T3.
  - T3 → T0 unconditionally.
- Outputs are combinational from state and IR. Any signal not listed for a state is 0:
  - T0: all outputs 0.
  - T1 LOAD: Extern = 1, Rin[Rx] = 1, Done = 1.
  - T1 MOVE: Rout[Ry] = 1, Rin[Rx] = 1, Done = 1.
  - T1 ADD/SUB: Rout[Rx] = 1, Ain = 1.
  - T2 ADD/SUB: Rout[Ry] = 1, Gin = 1, AddSub = F[0].
  - T3 ADD/SUB: Gout = 1, Rin[Rx] = 1, Done = 1.
- Bus exclusivity invariant: popcount({Rout, Extern, Gout}) ≤ 1 in every cycle, including during reset.
- MOVE with Rx = Ry is legal: Rout[i] and Rin[i] are both high in the same cycle.
- w is ignored outside T0. Func changes outside the latching edge have no effect.

## Timing
- Reset:
  - Resetn low forces state = T0 and IR = 0 immediately, without waiting for a clock edge.
  - All outputs go to 0 in the same cycle.
  - Reset asserted mid-instruction aborts it; Done is not asserted for the aborted instruction.
- Latency, counted from the edge that samples w = 1:
  - LOAD/MOVE: Done in the next cycle (1 cycle).
  - ADD/SUB: Done 3 cycles after that edge.
- Throughput:
  - The FSM returns to T0 after Done, so the next w is sampled at least one cycle after Done.
  - Minimum instruction period: 2 cycles for LOAD/MOVE, 4 cycles for ADD/SUB.
- w held high continuously starts a new instruction on every pass through T0, with Func re-sampled each time.
- Outputs are glitch-tolerant combinational signals. Downstream registers capture on the next rising Clock edge.

## Structure
- Shared package cpu_pkg:
  - Opcode constants OP_LOAD, OP_MOVE, OP_ADD, OP_SUB.
  - State encoding T0..T3 as a 2-bit typedef.
  - Field slice positions for F, Rx and Ry.
- Sub-module dec2to4: 2-bit to one-hot 4-bit decoder with an enable input. It is instantiated twice, once for Rx-selected enables and once for Ry-selected enables.

## Test plan
- Reset then idle:
  - Stimulus: Resetn = 0, then 1 with w = 0 for 5 cycles.
  - Required: all outputs 0 and state T0 throughout.
- LOAD:
  - Stimulus: w = 1, Func = 6'b00_10_xx.
  - Required: next cycle Extern = 1, Rin = 4'b0100, Done = 1; the cycle after, all outputs 0.
- MOVE:
  - Stimulus: w = 1, Func = 6'b01_01_11.
  - Required: T1 has Rout = 4'b1000, Rin = 4'b0010, Done = 1.
- SUB:
  - Stimulus: w = 1, Func = 6'b11_00_10.
  - Required, in order: T1 Rout = 0001 with Ain = 1; T2 Rout = 0100 with Gin = 1 and AddSub = 1; T3 Gout = 1 with Rin = 0001 and Done = 1.
  - Also: Func is changed to 6'b00_11_11 during T2, and the outputs are unaffected.
- Reset mid-ADD:
  - Stimulus: Resetn is dropped asynchronously during T2 of Func = 6'b10_11_00.
  - Required: outputs go to 0 before the next edge, and Done never pulses.
- Bus-exclusivity assertion:
  - Stimulus: 200 random instructions with w toggling randomly.
  - Required: popcount({Rout, Extern, Gout}) ≤ 1 on every cycle, and Done count equals the number of accepted starts.
